// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: bus widths, forward-select codes
// and the write-bus record used by the forwarding muxes.
package operand_fetch_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef enum logic [1:0] {
    FWD_ARRAY = 2'b00,
    FWD_VWB   = 2'b01,
    FWD_WB    = 2'b10,
    FWD_ZERO  = 2'b11
  } fwd_sel_e;

  // One writeback-style bus: enable, destination register and result.
  typedef struct packed {
    logic             we;
    logic [AW-1:0]    rdst;
    logic [WIDTH-1:0] data;
  } wr_bus_t;

  // A bus only forwards when it is actually writing the register being read.
  function automatic logic bus_hits(input wr_bus_t bus, input logic [AW-1:0] ea);
    return bus.we && (bus.rdst == ea);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Request, writeback, virtual-writeback and operand-result signals of the
// register-file read stage, bundled with producer (master) and stage (slave) views.
interface operand_fetch_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);

  logic             i_of_valid;
  logic             i_of_stall;
  logic [AW-1:0]    i_of_rs1;
  logic [AW-1:0]    i_of_rs2;
  logic [AW-1:0]    i_of_wb_rdst;
  logic             i_of_wb_reg_write;
  logic [WIDTH-1:0] i_of_wb_data;
  logic [AW-1:0]    i_of_vwb_rdst;
  logic             i_of_vwb_reg_write;
  logic [WIDTH-1:0] i_of_vwb_data;
  logic             o_of_valid;
  logic [WIDTH-1:0] o_of_rs1_data;
  logic [WIDTH-1:0] o_of_rs2_data;
  logic [1:0]       o_of_fwd_sel1;
  logic [1:0]       o_of_fwd_sel2;

  modport master (
    output i_of_valid, i_of_stall, i_of_rs1, i_of_rs2,
    output i_of_wb_rdst, i_of_wb_reg_write, i_of_wb_data,
    output i_of_vwb_rdst, i_of_vwb_reg_write, i_of_vwb_data,
    input  o_of_valid, o_of_rs1_data, o_of_rs2_data, o_of_fwd_sel1, o_of_fwd_sel2
  );

  modport slave (
    input  i_of_valid, i_of_stall, i_of_rs1, i_of_rs2,
    input  i_of_wb_rdst, i_of_wb_reg_write, i_of_wb_data,
    input  i_of_vwb_rdst, i_of_vwb_reg_write, i_of_vwb_data,
    output o_of_valid, o_of_rs1_data, o_of_rs2_data, o_of_fwd_sel1, o_of_fwd_sel2
  );

endinterface

// File: rtl/operand_fetch_fwd_mux.sv
// Combinational operand source selection for one read port:
// r0 zero, then live WB (youngest), then virtual WB, then the array word.
module operand_fwd_mux
  import operand_fetch_pkg::*;
(
  input  logic [AW-1:0]    ea,
  input  wr_bus_t          wb_bus,
  input  wr_bus_t          vwb_bus,
  input  logic [WIDTH-1:0] arr_data,
  output logic [WIDTH-1:0] data,
  output fwd_sel_e         sel
);

  always_comb begin
    data = arr_data;
    sel  = FWD_ARRAY;
    if (ea == '0) begin
      data = '0;
      sel  = FWD_ZERO;
    end else if (bus_hits(wb_bus, ea)) begin
      data = wb_bus.data;
      sel  = FWD_WB;
    end else if (bus_hits(vwb_bus, ea)) begin
      data = vwb_bus.data;
      sel  = FWD_VWB;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-file read stage: 32-entry array written from the virtual-WB bus,
// two registered read ports with WB/VWB forwarding and stall-held addresses.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  operand_fetch_if.slave ofi
);

  logic [WIDTH-1:0] mem_reg [NREGS];
  logic [NREGS-1:0] wr_en;
  logic             valid_reg;

  wr_bus_t          wb_bus;
  wr_bus_t          vwb_bus;

  logic [AW-1:0]    rs       [2];
  logic [AW-1:0]    ea       [2];
  logic [WIDTH-1:0] arr_word [2];
  logic [WIDTH-1:0] port_data[2];
  fwd_sel_e         port_sel [2];

  assign wb_bus  = '{we: ofi.i_of_wb_reg_write, rdst: ofi.i_of_wb_rdst, data: ofi.i_of_wb_data};
  assign vwb_bus = '{we: ofi.i_of_vwb_reg_write, rdst: ofi.i_of_vwb_rdst, data: ofi.i_of_vwb_data};

  assign rs[0] = ofi.i_of_rs1;
  assign rs[1] = ofi.i_of_rs2;

  // Per-entry write decode; entry 0 has no enable so r0 is hard zero.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_wr_dec
      if (gi == 0) begin : g_r0
        assign wr_en[gi] = 1'b0;
      end else begin : g_rn
        assign wr_en[gi] = vwb_bus.we && (vwb_bus.rdst == AW'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en[i]) begin
          mem_reg[i] <= vwb_bus.data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
    end else if (!ofi.i_of_stall) begin
      valid_reg <= ofi.i_of_valid;
    end
  end

  // Each port keeps its last unstalled address; data and select refresh every
  // cycle, so a stalled request sees writes that land while it waits.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [AW-1:0]    held_reg;
      logic [WIDTH-1:0] data_next;
      logic [WIDTH-1:0] data_reg;
      fwd_sel_e         sel_next;
      fwd_sel_e         sel_reg;

      assign ea[gi]       = ofi.i_of_stall ? held_reg : rs[gi];
      assign arr_word[gi] = mem_reg[ea[gi]];

      operand_fwd_mux u_fwd_mux (
        .ea       (ea[gi]),
        .wb_bus   (wb_bus),
        .vwb_bus  (vwb_bus),
        .arr_data (arr_word[gi]),
        .data     (data_next),
        .sel      (sel_next)
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          held_reg <= '0;
          data_reg <= '0;
          sel_reg  <= FWD_ARRAY;
        end else begin
          if (!ofi.i_of_stall) begin
            held_reg <= rs[gi];
          end
          data_reg <= data_next;
          sel_reg  <= sel_next;
        end
      end

      assign port_data[gi] = data_reg;
      assign port_sel[gi]  = sel_reg;
    end
  endgenerate

  assign ofi.o_of_valid    = valid_reg;
  assign ofi.o_of_rs1_data = port_data[0];
  assign ofi.o_of_rs2_data = port_data[1];
  assign ofi.o_of_fwd_sel1 = port_sel[0];
  assign ofi.o_of_fwd_sel2 = port_sel[1];

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, array path, forward priority,
// r0 guard, stall refresh and disabled-write handling.
module tb_operand_fetch;

  localparam int WIDTH = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  operand_fetch_if #(.WIDTH(WIDTH), .AW(AW)) ofi ();

  operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .ofi (ofi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("check %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rdst, input logic [31:0] data);
    ofi.i_of_wb_reg_write = we;
    ofi.i_of_wb_rdst      = rdst;
    ofi.i_of_wb_data      = data;
  endtask

  task automatic set_vwb(input logic we, input logic [4:0] rdst, input logic [31:0] data);
    ofi.i_of_vwb_reg_write = we;
    ofi.i_of_vwb_rdst      = rdst;
    ofi.i_of_vwb_data      = data;
  endtask

  task automatic req(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2);
    ofi.i_of_valid = valid;
    ofi.i_of_rs1   = rs1;
    ofi.i_of_rs2   = rs2;
  endtask

  initial begin
    ofi.i_of_stall = 1'b0;
    req(1'b0, 5'd0, 5'd0);
    set_wb(1'b0, 5'd0, 32'h0);
    set_vwb(1'b0, 5'd0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    check("reset_valid", {31'b0, ofi.o_of_valid}, 32'h0);
    check("reset_rs1", ofi.o_of_rs1_data, 32'h0);
    check("reset_sel1", {30'b0, ofi.o_of_fwd_sel1}, 32'h0);

    // Preload r1, read it back, then reset asynchronously mid-cycle.
    set_vwb(1'b1, 5'd1, 32'h0000_1111);
    tick();
    set_vwb(1'b0, 5'd0, 32'h0);
    req(1'b1, 5'd1, 5'd1);
    tick();
    check("preload_rs1", ofi.o_of_rs1_data, 32'h0000_1111);
    check("preload_valid", {31'b0, ofi.o_of_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, ofi.o_of_valid}, 32'h0);
    check("async_rst_rs1", ofi.o_of_rs1_data, 32'h0);
    check("async_rst_rs2", ofi.o_of_rs2_data, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      req(1'b1, 5'(i), 5'(31 - i));
      tick();
      check($sformatf("clr_rs1_r%0d", i), ofi.o_of_rs1_data, 32'h0);
      check($sformatf("clr_sel1_r%0d", i), {30'b0, ofi.o_of_fwd_sel1}, (i == 0) ? 32'h3 : 32'h0);
    end

    // Array path: write r5 and r9, read r5 two cycles after the r5 write.
    req(1'b0, 5'd0, 5'd0);
    set_vwb(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    set_vwb(1'b1, 5'd9, 32'h0000_9999);
    tick();
    set_vwb(1'b0, 5'd0, 32'h0);
    req(1'b1, 5'd5, 5'd0);
    tick();
    check("arr_rs1", ofi.o_of_rs1_data, 32'hDEAD_BEEF);
    check("arr_sel1", {30'b0, ofi.o_of_fwd_sel1}, 32'h0);
    check("arr_valid", {31'b0, ofi.o_of_valid}, 32'h1);

    // WB beats VWB on the same register; next cycle the VWB value is in the array.
    set_wb(1'b1, 5'd7, 32'h0000_0011);
    set_vwb(1'b1, 5'd7, 32'h0000_0022);
    req(1'b1, 5'd7, 5'd7);
    tick();
    check("prio_rs1", ofi.o_of_rs1_data, 32'h0000_0011);
    check("prio_rs2", ofi.o_of_rs2_data, 32'h0000_0011);
    check("prio_sel1", {30'b0, ofi.o_of_fwd_sel1}, 32'h2);
    check("prio_sel2", {30'b0, ofi.o_of_fwd_sel2}, 32'h2);
    set_wb(1'b0, 5'd0, 32'h0);
    set_vwb(1'b0, 5'd0, 32'h0);
    tick();
    check("prio_after_rs1", ofi.o_of_rs1_data, 32'h0000_0022);
    check("prio_after_sel1", {30'b0, ofi.o_of_fwd_sel1}, 32'h0);

    // Per-port sources: rs1 from WB, rs2 from VWB.
    set_wb(1'b1, 5'd5, 32'h0000_1234);
    set_vwb(1'b1, 5'd6, 32'h0000_5678);
    req(1'b1, 5'd5, 5'd6);
    tick();
    check("mix_rs1", ofi.o_of_rs1_data, 32'h0000_1234);
    check("mix_sel1", {30'b0, ofi.o_of_fwd_sel1}, 32'h2);
    check("mix_rs2", ofi.o_of_rs2_data, 32'h0000_5678);
    check("mix_sel2", {30'b0, ofi.o_of_fwd_sel2}, 32'h1);
    set_wb(1'b0, 5'd0, 32'h0);
    set_vwb(1'b0, 5'd0, 32'h0);
    tick();
    check("mix_rs1_arr", ofi.o_of_rs1_data, 32'hDEAD_BEEF);
    check("mix_rs2_arr", ofi.o_of_rs2_data, 32'h0000_5678);

    // r0 guard.
    set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_vwb(1'b1, 5'd0, 32'hFFFF_FFFF);
    req(1'b1, 5'd0, 5'd0);
    tick();
    check("r0_rs2", ofi.o_of_rs2_data, 32'h0);
    check("r0_sel2", {30'b0, ofi.o_of_fwd_sel2}, 32'h3);
    set_wb(1'b0, 5'd0, 32'h0);
    set_vwb(1'b0, 5'd0, 32'h0);
    tick();
    check("r0_after_rs2", ofi.o_of_rs2_data, 32'h0);

    // Stall: r3 request held while rs1 changes and r3 is written.
    req(1'b1, 5'd3, 5'd0);
    tick();
    check("stall_pre_rs1", ofi.o_of_rs1_data, 32'h0);
    ofi.i_of_stall = 1'b1;
    req(1'b0, 5'd9, 5'd0);
    set_vwb(1'b1, 5'd3, 32'h0000_0055);
    tick();
    check("stall_vwb_rs1", ofi.o_of_rs1_data, 32'h0000_0055);
    check("stall_vwb_sel1", {30'b0, ofi.o_of_fwd_sel1}, 32'h1);
    check("stall_valid_hold", {31'b0, ofi.o_of_valid}, 32'h1);
    set_vwb(1'b0, 5'd0, 32'h0);
    tick();
    check("stall_arr_rs1", ofi.o_of_rs1_data, 32'h0000_0055);
    check("stall_arr_sel1", {30'b0, ofi.o_of_fwd_sel1}, 32'h0);
    tick();
    check("stall_end_rs1", ofi.o_of_rs1_data, 32'h0000_0055);
    ofi.i_of_stall = 1'b0;
    req(1'b1, 5'd9, 5'd0);
    tick();
    check("release_rs1", ofi.o_of_rs1_data, 32'h0000_9999);
    check("release_sel1", {30'b0, ofi.o_of_fwd_sel1}, 32'h0);

    // Disabled writes are never forwarded.
    set_vwb(1'b1, 5'd4, 32'h0000_0044);
    req(1'b0, 5'd0, 5'd0);
    tick();
    set_vwb(1'b0, 5'd4, 32'h0000_00BB);
    set_wb(1'b0, 5'd4, 32'h0000_00AA);
    req(1'b1, 5'd4, 5'd4);
    tick();
    check("wen_low_rs1", ofi.o_of_rs1_data, 32'h0000_0044);
    check("wen_low_sel1", {30'b0, ofi.o_of_fwd_sel1}, 32'h0);
    check("wen_low_rs2", ofi.o_of_rs2_data, 32'h0000_0044);
    set_wb(1'b0, 5'd0, 32'h0);
    set_vwb(1'b0, 5'd0, 32'h0);
    tick();
    check("wen_low_after_rs1", ofi.o_of_rs1_data, 32'h0000_0044);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
